// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(7,4) bit layout, encode/syndrome helpers, FSM states
// Purpose: shared definitions for the codeword FIFO and the link controller.
// Contents: bit-index localparams, read-FSM state codes, hamming_encode,
//           hamming_syndrome, syndrome classification and bit-flip helpers.
package hamming_pkg;

  localparam int CW_W = 7;
  localparam int D_W  = 4;

  // Data bit positions inside the codeword
  localparam int D0_BIT = 2;
  localparam int D1_BIT = 4;
  localparam int D2_BIT = 5;
  localparam int D3_BIT = 6;

  // Parity bit positions inside the codeword
  localparam int P0_BIT = 0;
  localparam int P1_BIT = 1;
  localparam int P2_BIT = 3;

  // Read-side FSM state codes
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DECODE  = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  function automatic logic [CW_W-1:0] hamming_encode(input logic [D_W-1:0] d);
    logic [CW_W-1:0] cw;
    cw         = '0;
    cw[D3_BIT] = d[3];
    cw[D2_BIT] = d[2];
    cw[D1_BIT] = d[1];
    cw[D0_BIT] = d[0];
    cw[P0_BIT] = d[3] ^ d[1] ^ d[0];
    cw[P1_BIT] = d[3] ^ d[2] ^ d[0];
    cw[P2_BIT] = d[3] ^ d[2] ^ d[1];
    return cw;
  endfunction

  // A nonzero result S names codeword bit S-1 as the flipped one
  function automatic logic [2:0] hamming_syndrome(input logic [CW_W-1:0] cw);
    return {cw[P2_BIT] ^ cw[D3_BIT] ^ cw[D2_BIT] ^ cw[D1_BIT],
            cw[P1_BIT] ^ cw[D3_BIT] ^ cw[D2_BIT] ^ cw[D0_BIT],
            cw[P0_BIT] ^ cw[D3_BIT] ^ cw[D1_BIT] ^ cw[D0_BIT]};
  endfunction

  // Syndromes 3,5,6,7 point at c2,c4,c5,c6 (data bits)
  function automatic logic syn_hits_data(input logic [2:0] s);
    return (s == 3'd3) || (s == 3'd5) || (s == 3'd6) || (s == 3'd7);
  endfunction

  // Syndromes 1,2,4 point at c0,c1,c3 (parity bits)
  function automatic logic syn_hits_parity(input logic [2:0] s);
    return (s == 3'd1) || (s == 3'd2) || (s == 3'd4);
  endfunction

  // Flip bit pos-1; pos 0 leaves the word untouched
  function automatic logic [CW_W-1:0] flip_bit(input logic [CW_W-1:0] cw, input logic [2:0] pos);
    if (pos == 3'd0) return cw;
    return cw ^ (7'd1 << (pos - 3'd1));
  endfunction

  function automatic logic [D_W-1:0] cw_data(input logic [CW_W-1:0] cw);
    return {cw[D3_BIT], cw[D2_BIT], cw[D1_BIT], cw[D0_BIT]};
  endfunction

endpackage

// File: rtl/hamming_link_ctrl_if.sv
// rtl/hamming_link_ctrl_if.sv - upstream/downstream handshake bundle of the Hamming link
// Purpose: groups the input beat channel and the decoded output channel.
// Modports: master = traffic source/sink side, slave = hamming_link_ctrl side.
interface hamming_link_ctrl_if;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [2:0] inj_pos;

  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [3:0] out_raw;
  logic [2:0] out_syndrome;
  logic       out_corrected;
  logic       out_parity_err;

  modport master (
    output in_valid, in_data, inj_pos, out_ready,
    input  in_ready, out_valid, out_data, out_raw, out_syndrome,
           out_corrected, out_parity_err
  );

  modport slave (
    input  in_valid, in_data, inj_pos, out_ready,
    output in_ready, out_valid, out_data, out_raw, out_syndrome,
           out_corrected, out_parity_err
  );

endinterface

// File: rtl/hamming_cw_fifo.sv
// rtl/hamming_cw_fifo.sv - DEPTH-deep synchronous codeword FIFO
// Purpose: buffers encoded codewords between the write side and the read FSM.
// Ports: clk, rst (sync active-high), push/wdata, pop/rdata (head, combinational),
//        full, empty, fill (occupancy).
module hamming_cw_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (fill == (AW+1)'(DEPTH));
  assign empty = (fill == '0);

endmodule

// File: rtl/hamming_link_ctrl.sv
// rtl/hamming_link_ctrl.sv - flow-controlled Hamming(7,4) encode/buffer/decode link
// Purpose: encodes accepted nibbles (with optional injected fault), queues the
//          codewords, decodes/corrects one at a time and presents them downstream.
// Ports: clk, rst (sync active-high), link (slave modport: in_* beat channel,
//        out_* decoded channel), clr_stats, err_cnt (saturating), fill.
module hamming_link_ctrl
  import hamming_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  hamming_link_ctrl_if.slave     link,
  input  logic                   clr_stats,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [$clog2(DEPTH):0] fill
);

  logic [1:0]      state;
  logic [CW_W-1:0] cw_reg;
  logic [CW_W-1:0] head;
  logic [CW_W-1:0] wr_cw;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            out_hs;
  logic [2:0]      syn;

  logic            out_valid_q;
  logic [3:0]      out_data_q;
  logic [3:0]      out_raw_q;
  logic [2:0]      out_syn_q;
  logic            out_corr_q;
  logic            out_perr_q;

  // in_ready is held low during reset so nothing is accepted into a clearing FIFO
  assign link.in_ready = !full && !rst;
  assign push          = link.in_valid && link.in_ready;
  assign wr_cw         = flip_bit(hamming_encode(link.in_data), link.inj_pos);

  assign out_hs = out_valid_q && link.out_ready;
  assign pop    = !empty && ((state == ST_IDLE) || (state == ST_PRESENT && out_hs));
  assign syn    = hamming_syndrome(cw_reg);

  hamming_cw_fifo #(
    .DEPTH (DEPTH),
    .W     (CW_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_cw),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cw_reg      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_raw_q   <= '0;
      out_syn_q   <= '0;
      out_corr_q  <= 1'b0;
      out_perr_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            cw_reg <= head;
            state  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          out_raw_q   <= cw_data(cw_reg);
          // Only data-bit syndromes are flipped back; parity hits leave data as-is
          out_data_q  <= syn_hits_data(syn) ? cw_data(flip_bit(cw_reg, syn)) : cw_data(cw_reg);
          out_syn_q   <= syn;
          out_corr_q  <= syn_hits_data(syn);
          out_perr_q  <= syn_hits_parity(syn);
          out_valid_q <= 1'b1;
          state       <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (link.out_ready) begin
            out_valid_q <= 1'b0;
            if (!empty) begin
              cw_reg <= head;
              state  <= ST_DECODE;
            end else begin
              state  <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // clr_stats wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      err_cnt <= '0;
    end else if (out_hs && (out_syn_q != 3'd0) && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign link.out_valid      = out_valid_q;
  assign link.out_data       = out_data_q;
  assign link.out_raw        = out_raw_q;
  assign link.out_syndrome   = out_syn_q;
  assign link.out_corrected  = out_corr_q;
  assign link.out_parity_err = out_perr_q;

endmodule

// File: tb/tb_hamming_link_ctrl.sv
// tb/tb_hamming_link_ctrl.sv - directed self-checking bench for hamming_link_ctrl
module tb_hamming_link_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_stats = 1'b0;
  logic       clr2 = 1'b0;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [2:0] fill;
  logic [2:0] fill2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] sd [8];
  int acc;
  int got;

  hamming_link_ctrl_if lk ();
  hamming_link_ctrl_if lk2 ();

  hamming_link_ctrl #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .link      (lk.slave),
    .clr_stats (clr_stats),
    .err_cnt   (err_cnt),
    .fill      (fill)
  );

  hamming_link_ctrl #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .link      (lk2.slave),
    .clr_stats (clr2),
    .err_cnt   (err_cnt2),
    .fill      (fill2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic [2:0] pos);
    lk.in_valid = 1'b1;
    lk.in_data  = d;
    lk.inj_pos  = pos;
    for (int i = 0; i < 20 && !lk.in_ready; i++) tick();
    tick();
    lk.in_valid = 1'b0;
    for (int i = 0; i < 20 && !lk.out_valid; i++) tick();
    chk("send_out_valid", 32'(lk.out_valid), 32'd1);
  endtask

  task automatic send2(input logic [3:0] d, input logic [2:0] pos);
    lk2.in_valid = 1'b1;
    lk2.in_data  = d;
    lk2.inj_pos  = pos;
    for (int i = 0; i < 20 && !lk2.in_ready; i++) tick();
    tick();
    lk2.in_valid = 1'b0;
    for (int i = 0; i < 20 && !lk2.out_valid; i++) tick();
    chk("send2_out_valid", 32'(lk2.out_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) sd[i] = 4'(i * 5 + 3);
    lk.in_valid = 1'b0;  lk.in_data = '0;  lk.inj_pos = '0;  lk.out_ready = 1'b0;
    lk2.in_valid = 1'b0; lk2.in_data = '0; lk2.inj_pos = '0; lk2.out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(lk.out_valid), 32'd0);
    chk("rst_out_data", 32'(lk.out_data), 32'd0);
    chk("rst_out_raw", 32'(lk.out_raw), 32'd0);
    chk("rst_syndrome", 32'(lk.out_syndrome), 32'd0);
    chk("rst_corrected", 32'(lk.out_corrected), 32'd0);
    chk("rst_parity_err", 32'(lk.out_parity_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_in_ready", 32'(lk.in_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(lk.in_ready), 32'd1);

    // Clean beat 1011, latency 3 cycles
    lk.out_ready = 1'b1;
    lk.in_valid  = 1'b1;
    lk.in_data   = 4'b1011;
    lk.inj_pos   = 3'd0;
    tick();
    lk.in_valid = 1'b0;
    chk("t1_fill", 32'(fill), 32'd1);
    chk("t1_fifo_cw", 32'(dut.u_fifo.rdata), 32'b1010101);
    chk("t1_lat_e0", 32'(lk.out_valid), 32'd0);
    tick();
    chk("t1_lat_e1", 32'(lk.out_valid), 32'd0);
    tick();
    chk("t1_lat_e2", 32'(lk.out_valid), 32'd1);
    chk("t1_out_data", 32'(lk.out_data), 32'b1011);
    chk("t1_syndrome", 32'(lk.out_syndrome), 32'd0);
    tick();
    chk("t1_valid_drop", 32'(lk.out_valid), 32'd0);
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);

    // 1011 with c4 flipped
    send(4'b1011, 3'd5);
    chk("t2_raw", 32'(lk.out_raw), 32'b1001);
    chk("t2_syndrome", 32'(lk.out_syndrome), 32'b101);
    chk("t2_data", 32'(lk.out_data), 32'b1011);
    chk("t2_corrected", 32'(lk.out_corrected), 32'd1);
    chk("t2_parity_err", 32'(lk.out_parity_err), 32'd0);
    tick();
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);

    // 0110 with c3 flipped
    send(4'b0110, 3'd4);
    chk("t3_syndrome", 32'(lk.out_syndrome), 32'b100);
    chk("t3_parity_err", 32'(lk.out_parity_err), 32'd1);
    chk("t3_corrected", 32'(lk.out_corrected), 32'd0);
    chk("t3_data", 32'(lk.out_data), 32'b0110);
    chk("t3_raw", 32'(lk.out_raw), 32'b0110);
    tick();
    chk("t3_err_cnt", 32'(err_cnt), 32'd2);

    // Stall: offer DEPTH+2 beats with out_ready low
    lk.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      lk.in_valid = (acc < DEPTH + 2);
      lk.in_data  = sd[acc];
      lk.inj_pos  = 3'(acc + 1);
      if (lk.in_valid && lk.in_ready) acc++;
      tick();
    end
    lk.in_valid = 1'b0;
    chk("stall_accepted", 32'(acc), 32'(DEPTH + 1));
    chk("stall_in_ready", 32'(lk.in_ready), 32'd0);
    chk("stall_fill", 32'(fill), 32'(DEPTH));
    chk("stall_out_valid", 32'(lk.out_valid), 32'd1);
    chk("stall_data_a", 32'(lk.out_data), 32'(sd[0]));
    tick();
    tick();
    chk("stall_data_b", 32'(lk.out_data), 32'(sd[0]));
    chk("stall_syndrome", 32'(lk.out_syndrome), 32'b001);
    chk("stall_parity_err", 32'(lk.out_parity_err), 32'd1);

    lk.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < DEPTH + 1; c++) begin
      if (lk.out_valid && lk.out_ready) begin
        chk("drain_data", 32'(lk.out_data), 32'(sd[got]));
        got++;
      end
      tick();
    end
    chk("drain_count", 32'(got), 32'(DEPTH + 1));
    chk("drain_fill", 32'(fill), 32'd0);
    chk("drain_err_cnt", 32'(err_cnt), 32'd7);

    // Reset while presenting with two words queued
    lk.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      lk.in_valid = (acc < 3);
      lk.in_data  = sd[acc];
      lk.inj_pos  = 3'd0;
      if (lk.in_valid && lk.in_ready) acc++;
      tick();
    end
    lk.in_valid = 1'b0;
    chk("pre_rst_fill", 32'(fill), 32'd2);
    chk("pre_rst_valid", 32'(lk.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(lk.out_valid), 32'd0);
    chk("mid_rst_fill", 32'(fill), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_out_data", 32'(lk.out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(lk.in_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("after_rst_in_ready", 32'(lk.in_ready), 32'd1);
    chk("after_rst_valid", 32'(lk.out_valid), 32'd0);
    lk.out_ready = 1'b1;
    send(4'b0101, 3'd7);
    chk("after_rst_data", 32'(lk.out_data), 32'b0101);
    chk("after_rst_syndrome", 32'(lk.out_syndrome), 32'b111);
    chk("after_rst_corrected", 32'(lk.out_corrected), 32'd1);
    tick();
    chk("after_rst_err_cnt", 32'(err_cnt), 32'd1);

    // Saturating 2-bit counter, clear on the 5th handshake
    lk2.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send2(4'(k + 9), 3'(k + 1));
      chk("sat_data", 32'(lk2.out_data), 32'(k + 9));
      if (k == 4) clr2 = 1'b1;
      tick();
      clr2 = 1'b0;
      case (k)
        0: chk("sat_cnt", 32'(err_cnt2), 32'd1);
        1: chk("sat_cnt", 32'(err_cnt2), 32'd2);
        2: chk("sat_cnt", 32'(err_cnt2), 32'd3);
        3: chk("sat_cnt", 32'(err_cnt2), 32'd3);
        default: chk("sat_clr", 32'(err_cnt2), 32'd0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
